// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Four-master round-robin bus arbiter with registered, active-low grants.
//   A grant is held for as long as the owning master keeps its request low.
//   When the owner releases, the grant moves straight to the next requester in
//   round-robin order (no idle cycle), or the arbiter goes idle.
//
//   Optional feature (macro BUS_ARB_TIMEOUT_EN): an 8-bit grant-length counter
//   forcibly revokes a grant held for more than TIMEOUT_CYCLES cycles and
//   pulses Timeout for one cycle. With the macro undefined there is no
//   counter and Timeout is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  max consecutive grant cycles before forced revoke
//                   (only meaningful with BUS_ARB_TIMEOUT_EN)
// Ports
//   clk                 rising-edge clock
//   reset_              asynchronous active-low reset
//   M0Req_..M3Req_      active-low requests, held low for the transaction
//   M0Grnt_..M3Grnt_    active-low registered grants, at most one low
//   Owner               index of the current or most recent owner
//   Timeout             one-cycle pulse on forced revoke
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       M0Req_,
  input  logic       M1Req_,
  input  logic       M2Req_,
  input  logic       M3Req_,
  output logic       M0Grnt_,
  output logic       M1Grnt_,
  output logic       M2Grnt_,
  output logic       M3Grnt_,
  output logic [1:0] Owner,
  output logic       Timeout
);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] grnt_n_q, grnt_n_d;

  logic [3:0] req;
  logic [2:0] pick_all;    // {found, index}: search owner+1..owner+4
  logic [2:0] pick_other;  // {found, index}: search owner+1..owner+3 only
  logic       revoke;

  // Round-robin search starting after 'base'. The base itself is examined
  // last, and only when incl_base is set.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base,
                                         input logic       incl_base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = base;
    for (int i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!found && r[cand] && (i != 4 || incl_base)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [3:0] grant_vec(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign req        = ~{M3Req_, M2Req_, M1Req_, M0Req_};
  assign pick_all   = rr_pick(req, owner_q, 1'b1);
  // Used for handover: the owner is either not requesting (released) or has
  // timed out, and in both cases must not win the search.
  assign pick_other = rr_pick(req, owner_q, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       timeout_hit;

  assign timeout_hit = (state_q == ARB_GRANT) && req[owner_q] &&
                       (cnt_q == TIMEOUT_CYCLES);
  assign revoke      = !req[owner_q] || timeout_hit;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign revoke     = !req[owner_q];
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grnt_n_d = grnt_n_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_hit;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_all[2]) begin
          state_d  = ARB_GRANT;
          owner_d  = pick_all[1:0];
          grnt_n_d = grant_vec(pick_all[1:0]);
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end
      ARB_GRANT: begin
        if (revoke) begin
          if (pick_other[2]) begin
            owner_d  = pick_other[1:0];
            grnt_n_d = grant_vec(pick_other[1:0]);
          end else begin
            // Owner is kept so the next search resumes after it.
            state_d  = ARB_IDLE;
            grnt_n_d = 4'hF;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        grnt_n_d = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ARB_IDLE;
      owner_q  <= 2'd3;
      grnt_n_q <= 4'hF;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grnt_n_q <= grnt_n_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  assign M0Grnt_ = grnt_n_q[0];
  assign M1Grnt_ = grnt_n_q[1];
  assign M2Grnt_ = grnt_n_q[2];
  assign M3Grnt_ = grnt_n_q[3];
  assign Owner   = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed self-checking bench for bus_arbiter. Grants are collected as an
//   active-low vector {M3,M2,M1,M0}; expected values are written by hand.
//   The instance uses TIMEOUT_CYCLES = 4 so the timeout section is short when
//   BUS_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] req_n;
  logic       M0Grnt_, M1Grnt_, M2Grnt_, M3Grnt_;
  logic [1:0] Owner;
  logic       Timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .M0Req_  (req_n[0]),
    .M1Req_  (req_n[1]),
    .M2Req_  (req_n[2]),
    .M3Req_  (req_n[3]),
    .M0Grnt_ (M0Grnt_),
    .M1Grnt_ (M1Grnt_),
    .M2Grnt_ (M2Grnt_),
    .M3Grnt_ (M3Grnt_),
    .Owner   (Owner),
    .Timeout (Timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] g_exp,
                     input logic [1:0] o_exp, input logic t_exp);
    logic [3:0] g;
    g = {M3Grnt_, M2Grnt_, M1Grnt_, M0Grnt_};
    checks++;
    assert (g === g_exp) else begin
      errors++;
      $error("FAIL %s grants=%b expected %b", tag, g, g_exp);
    end
    checks++;
    assert (Owner === o_exp) else begin
      errors++;
      $error("FAIL %s owner=%0d expected %0d", tag, Owner, o_exp);
    end
    checks++;
    assert (Timeout === t_exp) else begin
      errors++;
      $error("FAIL %s timeout=%b expected %b", tag, Timeout, t_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gexp;
    logic [1:0] nxt;

    reset_ = 1'b0;
    req_n  = 4'b1111;
    #12;
    chk("reset", 4'b1111, 2'd3, 1'b0);

    // First request after reset: M2 alone.
    reset_ = 1'b1;
    req_n  = 4'b1011;
    step();
    chk("first_grant_m2", 4'b1011, 2'd2, 1'b0);

    // Release with nobody waiting: idle, owner kept.
    req_n = 4'b1111;
    step();
    chk("release_idle", 4'b1111, 2'd2, 1'b0);
    step();
    chk("stay_idle", 4'b1111, 2'd2, 1'b0);

    req_n = 4'b0111;
    step();
    chk("grant_m3", 4'b0111, 2'd3, 1'b0);

    // Everyone requests; owner M3 holds without preemption.
    req_n = 4'b0000;
    step();
    chk("hold_m3", 4'b0111, 2'd3, 1'b0);
    req_n = 4'b1000;
    step();
    chk("wrap_to_m0", 4'b1110, 2'd0, 1'b0);
    req_n = 4'b0000;

    // Each owner keeps the grant 3 cycles, then drops its request for one
    // edge: expected order 0,1,2,3,0 with no idle cycle in between.
    for (int k = 0; k < 4; k++) begin
      gexp = ~(4'b0001 << k);
      step();
      chk("rr_hold_a", gexp, 2'(k), 1'b0);
      step();
      chk("rr_hold_b", gexp, 2'(k), 1'b0);
      req_n[k] = 1'b1;
      step();
      nxt  = 2'(k + 1);
      gexp = ~(4'b0001 << nxt);
      chk("rr_handover", gexp, nxt, 1'b0);
      req_n[k] = 1'b0;
    end

    // Owner 3 releases with M1 and M3... M1 waiting: wraps past 0 to 1.
    req_n = 4'b0111;
    step();
    chk("only_m3_left", 4'b0111, 2'd3, 1'b0);
    req_n = 4'b0101;
    step();
    chk("m3_holds", 4'b0111, 2'd3, 1'b0);
    req_n = 4'b1101;
    step();
    chk("wrap_first_hit_m1", 4'b1101, 2'd1, 1'b0);

    // Release to idle, then a new request is granted one cycle later.
    req_n = 4'b1111;
    step();
    chk("idle_after_m1", 4'b1111, 2'd1, 1'b0);
    step();
    chk("idle_hold_owner", 4'b1111, 2'd1, 1'b0);
    req_n = 4'b1010;
    step();
    chk("rr_from_1_picks_m2", 4'b1011, 2'd2, 1'b0);
    step();
    chk("m2_holds_vs_m0", 4'b1011, 2'd2, 1'b0);

    // M0 gives up before being granted: must not be remembered.
    req_n = 4'b1011;
    step();
    chk("m0_dropped", 4'b1011, 2'd2, 1'b0);
    req_n = 4'b1111;
    step();
    chk("no_latched_req", 4'b1111, 2'd2, 1'b0);
    step();
    chk("still_idle", 4'b1111, 2'd2, 1'b0);

    // Asynchronous reset in the middle of a grant, between clock edges.
    req_n = 4'b1110;
    step();
    chk("grant_m0", 4'b1110, 2'd0, 1'b0);
    #3;
    reset_ = 1'b0;
    #1;
    chk("async_reset", 4'b1111, 2'd3, 1'b0);
    #2;
    reset_ = 1'b1;
    req_n  = 4'b1100;
    step();
    chk("post_reset_m0_first", 4'b1110, 2'd0, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
    req_n = 4'b1111;
    step();
    chk("to_idle", 4'b1111, 2'd0, 1'b0);
    req_n = 4'b1101;
    step();
    chk("to_grant_m1", 4'b1101, 2'd1, 1'b0);
    req_n = 4'b1001;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("to_hold_m1", 4'b1101, 2'd1, 1'b0);
    end
    step();
    chk("to_revoke_to_m2", 4'b1011, 2'd2, 1'b1);
    step();
    chk("to_pulse_ends", 4'b1011, 2'd2, 1'b0);

    req_n = 4'b1101;
    step();
    chk("to_back_to_m1", 4'b1101, 2'd1, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("to_hold_m1_alone", 4'b1101, 2'd1, 1'b0);
    end
    step();
    chk("to_revoke_idle", 4'b1111, 2'd1, 1'b1);
    step();
    chk("to_regrant_m1", 4'b1101, 2'd1, 1'b0);
    req_n = 4'b1111;
    step();
    chk("to_final_idle", 4'b1111, 2'd1, 1'b0);
`else
    // No timeout logic: the grant is held indefinitely despite M1 waiting.
    for (int e = 0; e < 10; e++) begin
      step();
      chk("no_timeout_hold", 4'b1110, 2'd0, 1'b0);
    end
    req_n = 4'b1101;
    step();
    chk("handover_m1", 4'b1101, 2'd1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
